input_event_sequencer: RTL and testbench
========================================

# input_event_sequencer

Converts the two asynchronous game inputs into single-cycle interrupt instructions for the CPU. The inputs are the debounced jump key and the frame-rate tick. The block sits between the raw input sources (keyboard/button jump line, frame_rate clock divider output) and the CPU's `interrupt_instruction` port, in the processor clock domain. Events are counted per source and issued one at a time under round-robin arbitration whenever the CPU signals it can take an injected instruction.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive processor cycles the synchronized key must hold a new level before it is accepted (≥1).
- `PEND_W`, default 3: width of each per-source pending counter; saturates at 2^PEND_W−1.
- `JUMP_INSTR`, default 32'h298C0001 (`addi r6, r6, 1`): word injected per jump event.
- `FRAME_INSTR`, default 32'h29CE0001 (`addi r7, r7, 1`): word injected per frame tick.

Ports:
- `clock`  in  1  processor clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `jump_key`  in  1  raw, bouncing, asynchronous jump level (1 = pressed).
- `frame_tick`  in  1  asynchronous frame-rate clock level; each rising edge is one frame.
- `int_ready`  in  1  CPU can accept an injected instruction this cycle.
- `interrupt_instruction`  out  32  injected word; 32'h0 (nop) when nothing is issued.
- `interrupt_valid`  out  1  1 for exactly the cycle `interrupt_instruction` is nonzero.
- `overflow`  out  2  sticky drop flags, bit0 = jump, bit1 = frame.

## Operation

- Jump path:
  - Two-flop synchronizer, then debouncer.
  - The debouncer holds a `stable` level and a counter. The counter increments each edge that the synchronized value ≠ `stable`, and clears when they are equal.
  - On the DEBOUNCE_CYCLES-th consecutive differing edge, `stable` takes the new level and the counter clears.
  - A registered rising-edge detect on `stable` produces one jump event per press. Releases produce nothing.
- Frame path: two-flop synchronizer plus a third flop for edge detect. Each 0→1 of the synchronized level is one frame event.
- Pending counters, one per source:
  - An event increments; a grant decrements.
  - Event and grant on the same edge: net unchanged.
  - Event while saturated: event dropped, matching `overflow` bit set. The bit clears only on reset.
- Arbiter:
  - On each edge with `int_ready`=1 and any counter nonzero, grant one source.
  - If both are nonzero, grant the source not granted last. The `last_grant` register resets to jump, so frame wins the first tie.
- Output register:
  - On a grant edge, load the source's instruction word and set `interrupt_valid`=1.
  - On any other edge, load 0 and set `interrupt_valid`=0.
  - Output is never held across cycles; the CPU must consume it in the cycle it is valid.
- Reset values: `interrupt_instruction`=0, `interrupt_valid`=0, `overflow`=0, all counters, synchronizers and `stable`=0, `last_grant`=jump.
- Reset asserted mid-operation discards all pending events. An event in the synchronizers at deassertion is lost.

## Timing

- Jump latency, counting the edge that first samples `jump_key`=1 as edge 1 (key clean, `int_ready`=1, no frame pending):
  - `stable` rises at edge DEBOUNCE_CYCLES+2.
  - Counter increments at edge D+3.
  - `interrupt_valid` is high after edge D+4, for one cycle.
- Frame latency: same counting gives `interrupt_valid` after edge 4.
- A bounce shorter than DEBOUNCE_CYCLES cycles resets the debounce count and produces no event.
- Issue rate: at most one instruction per cycle.
- With `int_ready` held high and both counters nonzero, output alternates frame/jump on consecutive cycles.
- `int_ready`=0 stalls issue with no loss. Counters keep accumulating up to saturation.

## Structure

- Shared package `game_io_pkg`:
  - ISA field constants (opcode [31:27], rd [26:22], rs [21:17], imm [16:0]).
  - `ADDI_OPCODE`=5'b00101.
  - Default `JUMP_INSTR`/`FRAME_INSTR` words.
  - Source index enum {SRC_JUMP=0, SRC_FRAME=1}.
- Sub-module `key_debouncer` (synchronizer + debounce counter + `stable`, parameter DEBOUNCE_CYCLES).
- Pending counters, arbiter and output register stay inline.

## Test plan

- DEBOUNCE_CYCLES=4, `int_ready`=1:
  - Clean press held 20 cycles → one cycle of `interrupt_valid`=1 with 32'h298C0001 after edge 8.
  - Release produces nothing.
- Bouncing key: 1 for 3 cycles, 0 for 1, 1 for 3, 0 → no instruction ever issued, `overflow`=0.
- Jump and frame events land on the same edge, `int_ready`=1 → 32'h29CE0001 in one cycle, then 32'h298C0001 in the next cycle, then 0.
- `int_ready`=0, 10 frame ticks → frame counter saturates at 7 and `overflow`=2'b10. Raising `int_ready` → exactly 7 consecutive FRAME_INSTR cycles.
- Reset pulsed low while 3 jumps are pending → outputs 0 immediately (asynchronous). After release, no instruction issues until a new event.
- Event increment and grant on the same edge with counter=1 → counter stays 1, and a second instruction issues on the next cycle.

Source files
------------

// File: rtl/game_io_pkg.sv
// rtl/game_io_pkg.sv - shared ISA field layout, default injected words and source indices
package game_io_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RD_MSB     = 26;
  localparam int RD_LSB     = 22;
  localparam int RS_MSB     = 21;
  localparam int RS_LSB     = 17;
  localparam int IMM_MSB    = 16;
  localparam int IMM_LSB    = 0;

  localparam logic [4:0] ADDI_OPCODE = 5'b00101;

  // addi r6, r6, 1 and addi r7, r7, 1
  localparam logic [31:0] DEFAULT_JUMP_INSTR  = 32'h298C0001;
  localparam logic [31:0] DEFAULT_FRAME_INSTR = 32'h29CE0001;

  typedef enum logic {
    SRC_JUMP  = 1'b0,
    SRC_FRAME = 1'b1
  } src_e;

endpackage

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - two-flop synchronizer followed by a consecutive-cycle level debouncer
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Any cycle agreeing with the accepted level restarts the count, so bounces never accumulate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], key_raw};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_sequencer.sv
// rtl/input_event_sequencer.sv - turns jump presses and frame ticks into round-robin injected instructions
module input_event_sequencer
  import game_io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          PEND_W          = 3,
  parameter logic [31:0] JUMP_INSTR      = DEFAULT_JUMP_INSTR,
  parameter logic [31:0] FRAME_INSTR     = DEFAULT_FRAME_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jump_key,
  input  logic        frame_tick,
  input  logic        int_ready,
  output logic [31:0] interrupt_instruction,
  output logic        interrupt_valid,
  output logic [1:0]  overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic              jump_stable;
  logic              jump_stable_d;
  logic [2:0]        frame_sync;
  logic              jump_event;
  logic              frame_event;
  logic [PEND_W-1:0] jump_pend;
  logic [PEND_W-1:0] frame_pend;
  src_e              last_grant;
  src_e              grant_src;
  logic              grant_valid;
  logic              jump_grant;
  logic              frame_grant;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_jump_debouncer (
    .clock  (clock),
    .reset  (reset),
    .key_raw(jump_key),
    .stable (jump_stable)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jump_stable_d <= 1'b0;
      frame_sync    <= '0;
    end else begin
      jump_stable_d <= jump_stable;
      frame_sync    <= {frame_sync[1:0], frame_tick};
    end
  end

  assign jump_event  = jump_stable & ~jump_stable_d;
  assign frame_event = frame_sync[1] & ~frame_sync[2];

  // On a tie the source that lost last time wins, so neither can starve the other.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_JUMP;
    if (int_ready) begin
      if (jump_pend != '0 && frame_pend != '0) begin
        grant_valid = 1'b1;
        grant_src   = (last_grant == SRC_JUMP) ? SRC_FRAME : SRC_JUMP;
      end else if (jump_pend != '0) begin
        grant_valid = 1'b1;
        grant_src   = SRC_JUMP;
      end else if (frame_pend != '0) begin
        grant_valid = 1'b1;
        grant_src   = SRC_FRAME;
      end
    end
    jump_grant  = grant_valid && (grant_src == SRC_JUMP);
    frame_grant = grant_valid && (grant_src == SRC_FRAME);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      jump_pend  <= '0;
      frame_pend <= '0;
      overflow   <= 2'b00;
    end else begin
      if (jump_event && !jump_grant) begin
        if (jump_pend == PEND_MAX) overflow[0] <= 1'b1;
        else jump_pend <= jump_pend + PEND_W'(1);
      end else if (!jump_event && jump_grant) begin
        jump_pend <= jump_pend - PEND_W'(1);
      end

      if (frame_event && !frame_grant) begin
        if (frame_pend == PEND_MAX) overflow[1] <= 1'b1;
        else frame_pend <= frame_pend + PEND_W'(1);
      end else if (!frame_event && frame_grant) begin
        frame_pend <= frame_pend - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      interrupt_instruction <= '0;
      interrupt_valid       <= 1'b0;
      last_grant            <= SRC_JUMP;
    end else if (grant_valid) begin
      interrupt_instruction <= (grant_src == SRC_FRAME) ? FRAME_INSTR : JUMP_INSTR;
      interrupt_valid       <= 1'b1;
      last_grant            <= grant_src;
    end else begin
      interrupt_instruction <= '0;
      interrupt_valid       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_event_sequencer.sv
// tb/tb_input_event_sequencer.sv - self-checking bench for input_event_sequencer
module tb_input_event_sequencer;

  localparam int          DEB = 4;
  localparam logic [31:0] JI  = 32'h298C0001;
  localparam logic [31:0] FI  = 32'h29CE0001;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        jump_key   = 1'b0;
  logic        frame_tick = 1'b0;
  logic        int_ready  = 1'b0;
  logic [31:0] interrupt_instruction;
  logic        interrupt_valid;
  logic [1:0]  overflow;

  int checks     = 0;
  int errors     = 0;
  int valid_seen = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic        frame;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;
  vec_t vecs[12];

  input_event_sequencer #(
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .jump_key             (jump_key),
    .frame_tick           (frame_tick),
    .int_ready            (int_ready),
    .interrupt_instruction(interrupt_instruction),
    .interrupt_valid      (interrupt_valid),
    .overflow             (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    jump_key   = 1'b0;
    frame_tick = 1'b0;
    int_ready  = 1'b0;
    reset      = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Scoreboard consumer: every issued word must match the oldest expected word.
  always @(negedge clock) begin
    if (reset) begin
      check("valid_vs_word", {31'd0, interrupt_valid}, {31'd0, interrupt_instruction != 32'd0});
      if (interrupt_valid) begin
        valid_seen++;
        if (sb.size() == 0) check("sb_unexpected", interrupt_instruction, 32'd0);
        else check("sb_word", interrupt_instruction, sb.pop_front());
      end
    end
  end

  initial begin
    int   snap;
    logic prev_frame;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, FI};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, FI};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'd0};

    // Reset state
    step();
    check("reset_valid", {31'd0, interrupt_valid}, 32'd0);
    check("reset_instr", interrupt_instruction, 32'd0);
    check("reset_overflow", {30'd0, overflow}, 32'd0);
    reset = 1'b1;
    step();

    // Clean press: one jump word after edge DEB+4
    int_ready = 1'b1;
    sb.push_back(JI);
    jump_key = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("press_valid_e%0d", k), {31'd0, interrupt_valid}, {31'd0, (k == DEB + 4)});
    end
    snap = valid_seen;
    jump_key = 1'b0;
    repeat (20) step();
    check("release_quiet", valid_seen - snap, 0);
    check("press_sb_empty", sb.size(), 0);

    // Bouncing key never settles
    snap = valid_seen;
    jump_key = 1'b1; repeat (3) step();
    jump_key = 1'b0; step();
    jump_key = 1'b1; repeat (3) step();
    jump_key = 1'b0; repeat (20) step();
    check("bounce_no_issue", valid_seen - snap, 0);
    check("bounce_overflow", {30'd0, overflow}, 32'd0);

    // Table-driven frame latency and stall vectors
    prev_frame = 1'b0;
    for (int i = 0; i < 12; i++) begin
      frame_tick = vecs[i].frame;
      int_ready  = vecs[i].ready;
      if (vecs[i].frame && !prev_frame) sb.push_back(FI);
      prev_frame = vecs[i].frame;
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, interrupt_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_instr", i), interrupt_instruction, vecs[i].exp_instr);
    end
    frame_tick = 1'b0;
    repeat (4) step();
    check("table_sb_empty", sb.size(), 0);

    // Jump and frame events on the same edge: frame wins the first tie
    do_reset();
    int_ready = 1'b1;
    sb.push_back(FI);
    sb.push_back(JI);
    jump_key = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 5) frame_tick = 1'b1;
      step();
      check($sformatf("tie_instr_e%0d", k), interrupt_instruction,
            (k == DEB + 4) ? FI : ((k == DEB + 5) ? JI : 32'd0));
    end
    jump_key = 1'b0;
    frame_tick = 1'b0;
    repeat (12) step();
    check("tie_sb_empty", sb.size(), 0);

    // Saturation with int_ready low, then drain
    do_reset();
    snap = valid_seen;
    for (int t = 0; t < 10; t++) begin
      frame_tick = 1'b1; repeat (2) step();
      frame_tick = 1'b0; repeat (2) step();
    end
    repeat (4) step();
    check("sat_stalled", valid_seen - snap, 0);
    check("sat_overflow", {30'd0, overflow}, 32'd2);
    repeat (7) sb.push_back(FI);
    int_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("drain_valid_c%0d", k), {31'd0, interrupt_valid}, {31'd0, (k <= 7)});
    end
    check("drain_sb_empty", sb.size(), 0);
    check("drain_overflow_sticky", {30'd0, overflow}, 32'd2);

    // Asynchronous reset discards pending jumps
    do_reset();
    for (int p = 0; p < 3; p++) begin
      jump_key = 1'b1; repeat (10) step();
      jump_key = 1'b0; repeat (10) step();
    end
    sb.push_back(JI);
    int_ready = 1'b1;
    step();
    check("prereset_instr", interrupt_instruction, JI);
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("async_valid", {31'd0, interrupt_valid}, 32'd0);
    check("async_instr", interrupt_instruction, 32'd0);
    check("async_overflow", {30'd0, overflow}, 32'd0);
    step();
    reset = 1'b1;
    snap = valid_seen;
    repeat (20) step();
    check("postreset_quiet", valid_seen - snap, 0);
    sb.push_back(FI);
    frame_tick = 1'b1; repeat (3) step();
    frame_tick = 1'b0; repeat (5) step();
    check("postreset_new_event", valid_seen - snap, 1);
    check("postreset_sb_empty", sb.size(), 0);

    // Event and grant on the same edge with one pending
    do_reset();
    sb.push_back(FI);
    frame_tick = 1'b1; repeat (3) step();
    frame_tick = 1'b0; repeat (3) step();
    sb.push_back(FI);
    frame_tick = 1'b1;
    step();
    step();
    int_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("same_edge_valid_c%0d", k), {31'd0, interrupt_valid}, {31'd0, (k <= 2)});
    end
    frame_tick = 1'b0;
    repeat (4) step();
    check("same_edge_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
